// File: rtl/toy_rr_arb.sv
`timescale 1ns/1ps
// Round-robin arbiter: picks one requester starting after the last winner.
// Latency: grant is combinational in the request cycle; pointer updates on grant.
// Backpressure: en=0 suppresses all grants and freezes the pointer.
// Ports: req (request vector), en (slot available), gnt (one-hot or zero),
//        gnt_idx (binary index of gnt, valid when gnt != 0).
module toy_rr_arb #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] last_q, last_d;
  logic [IW:0]   cand;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    last_d  = last_q;
    cand    = '0;
    found   = 1'b0;
    // Walk ports last+1, last+2, ... wrapping, so the previous winner is checked last.
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (en && !found && req[cand[IW-1:0]]) begin
        found                 = 1'b1;
        gnt[cand[IW-1:0]]     = 1'b1;
        gnt_idx               = cand[IW-1:0];
        last_d                = cand[IW-1:0];
      end
    end
  end

  // Reset to the highest port so port 0 wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= IW'(N-1);
    else        last_q <= last_d;
  end
endmodule

// File: rtl/toy_mem_arbiter.sv
`timescale 1ns/1ps
// Shares one single-ported 1-cycle memory among NUM_PORT requesters, round-robin.
// Latency: memory access in the grant cycle, response valid the next cycle.
// Backpressure: one outstanding response; a stalled response blocks new grants.
// Ports: req_* per-port flattened request buses (port p at slice p), rsp_vld/rsp_rdy
//        per-port response handshake, rsp_rd_data shared; mem_* drive the memory.
module toy_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORT   = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_PORT-1:0]                req_vld,
  output logic [NUM_PORT-1:0]                req_rdy,
  input  logic [NUM_PORT*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_PORT-1:0]                req_wr_en,
  input  logic [NUM_PORT*DATA_WIDTH-1:0]     req_wr_data,
  input  logic [NUM_PORT*DATA_WIDTH/8-1:0]   req_wr_byte_en,
  output logic [NUM_PORT-1:0]                rsp_vld,
  input  logic [NUM_PORT-1:0]                rsp_rdy,
  output logic [DATA_WIDTH-1:0]              rsp_rd_data,
  output logic                               mem_en,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  input  logic [DATA_WIDTH-1:0]              mem_rd_data,
  output logic [DATA_WIDTH-1:0]              mem_wr_data,
  output logic [DATA_WIDTH/8-1:0]            mem_wr_byte_en,
  output logic                               mem_wr_en
);
  localparam int IW = $clog2(NUM_PORT);
  localparam int BW = DATA_WIDTH / 8;

  logic                pend_q, pend_d;
  logic [IW-1:0]       pend_id_q, pend_id_d;
  logic [NUM_PORT-1:0] gnt;
  logic [IW-1:0]       gnt_idx;
  logic                rsp_acc, slot_free, arb_en;

  assign rsp_acc   = pend_q && rsp_rdy[pend_id_q];
  // Accepting the pending response frees the slot in the same cycle.
  assign slot_free = !pend_q || rsp_acc;
  // rst_n gates the grant so nothing reaches the memory while reset is held.
  assign arb_en    = rst_n && slot_free;

  toy_rr_arb #(.N(NUM_PORT)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_vld),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_rdy = gnt;
  // Memory holds its output while idle, so no data register is needed.
  assign rsp_rd_data = mem_rd_data;

  always_comb begin
    mem_en         = |gnt;
    mem_addr       = '0;
    mem_wr_data    = '0;
    mem_wr_byte_en = '0;
    mem_wr_en      = 1'b0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (gnt[p]) begin
        mem_addr       = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wr_data    = req_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        mem_wr_byte_en = req_wr_byte_en[p*BW +: BW];
        mem_wr_en      = req_wr_en[p];
      end
    end
  end

  always_comb begin
    rsp_vld = '0;
    if (pend_q) rsp_vld[pend_id_q] = 1'b1;
  end

  always_comb begin
    pend_d    = pend_q;
    pend_id_d = pend_id_q;
    if (mem_en) begin
      pend_d    = 1'b1;
      pend_id_d = gnt_idx;
    end else if (rsp_acc) begin
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 1'b0;
      pend_id_q <= '0;
    end else begin
      pend_q    <= pend_d;
      pend_id_q <= pend_id_d;
    end
  end
endmodule

// File: tb/tb_toy_mem_arbiter.sv
`timescale 1ns/1ps
module tb_toy_mem_arbiter;
  logic        clk;
  logic        rst_n;
  logic [1:0]  req_vld, req_rdy, req_wr_en, rsp_vld, rsp_rdy;
  logic [63:0] req_addr, req_wr_data;
  logic [7:0]  req_wr_byte_en;
  logic [31:0] rsp_rd_data, mem_addr, mem_rd_data, mem_wr_data;
  logic        mem_en, mem_wr_en;
  logic [3:0]  mem_wr_byte_en;

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          n_rsp    = 0;
  bit          auto_drop = 1'b1;
  logic [31:0] mem [256];

  toy_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_PORT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
    .req_wr_en(req_wr_en), .req_wr_data(req_wr_data), .req_wr_byte_en(req_wr_byte_en),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rd_data(rsp_rd_data),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_data(mem_wr_data), .mem_wr_byte_en(mem_wr_byte_en), .mem_wr_en(mem_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 1-cycle read latency, output held while mem_en is low.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem_rd_data = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) begin
        for (int b = 0; b < 4; b++)
          if (mem_wr_byte_en[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wr_data[b*8 +: 8];
      end else begin
        mem_rd_data <= mem[mem_addr[7:0]];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int port, input bit wr, input logic [31:0] data);
    exp_t e;
    e.port = port; e.wr = wr; e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic set_req(input int p, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    req_addr[p*32 +: 32]      = a;
    req_wr_data[p*32 +: 32]   = d;
    req_wr_byte_en[p*4 +: 4]  = be;
    req_wr_en[p]              = wr;
    req_vld[p]                = 1'b1;
  endtask

  // Called at a negedge: advance to just after the next posedge, retiring accepted requests.
  task automatic tick();
    logic [1:0] acc;
    acc = req_vld & req_rdy;
    @(posedge clk); #1;
    if (auto_drop) req_vld = req_vld & ~acc;
  endtask

  // Monitor: pops the scoreboard on every accepted response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("rsp_vld_onehot", 64'($countones(rsp_vld) <= 1), 64'd1);
      for (int p = 0; p < 2; p++) begin
        if (rsp_vld[p] && rsp_rdy[p]) begin
          n_rsp++;
          if (sb_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL rsp_unexpected: got response on port %0d, expected none", p);
          end else begin
            e = sb_q.pop_front();
            chk("rsp_port", 64'(p), 64'(e.port));
            if (!e.wr) chk("rsp_data", 64'(rsp_rd_data), 64'(e.data));
          end
        end
      end
    end
  end

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; req_vld = '0; rsp_rdy = '0; req_wr_en = '0;
    req_addr = '0; req_wr_data = '0; req_wr_byte_en = '0;
    @(posedge clk); @(posedge clk); #1;
    // Reset: requests present but everything held quiet.
    set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h20, 32'h1234, 4'hF);
    rsp_rdy = 2'b11;
    @(negedge clk);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Two conflicting reads: port 0 first, then port 1.
    set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
    push(0, 1'b0, 32'hDEAD_0010);
    push(1, 1'b0, 32'hDEAD_0020);
    @(negedge clk);
    chk("t1_gnt0", 64'(req_rdy), 64'b01);
    chk("t1_mem_en", 64'(mem_en), 64'd1);
    chk("t1_addr0", 64'(mem_addr), 64'h10);
    chk("t1_rsp_none", 64'(rsp_vld), 64'b00);
    tick();
    @(negedge clk);
    chk("t1_gnt1", 64'(req_rdy), 64'b10);
    chk("t1_addr1", 64'(mem_addr), 64'h20);
    chk("t1_rsp0", 64'(rsp_vld), 64'b01);
    tick();
    @(negedge clk);
    chk("t1_rsp1", 64'(rsp_vld), 64'b10);
    chk("t1_idle_en", 64'(mem_en), 64'd0);
    tick();
    @(negedge clk);
    chk("t1_drained", 64'(rsp_vld), 64'b00);
    tick();

    // Partial write then read-back from port 1.
    set_req(1, 1'b1, 32'h5, 32'hA5A5_A5A5, 4'b0011);
    push(1, 1'b1, 32'h0);
    @(negedge clk);
    chk("t2_gnt_wr", 64'(req_rdy), 64'b10);
    chk("t2_mem_wr_en", 64'(mem_wr_en), 64'd1);
    chk("t2_byte_en", 64'(mem_wr_byte_en), 64'b0011);
    chk("t2_wr_data", 64'(mem_wr_data), 64'hA5A5_A5A5);
    chk("t2_addr", 64'(mem_addr), 64'h5);
    tick();
    set_req(1, 1'b0, 32'h5, 32'h0, 4'h0);
    push(1, 1'b0, 32'hDEAD_A5A5);
    @(negedge clk);
    chk("t2_gnt_rd_b2b", 64'(req_rdy), 64'b10);
    chk("t2_rd_wr_en", 64'(mem_wr_en), 64'd0);
    tick();
    @(negedge clk);
    chk("t2_rsp_rd", 64'(rsp_vld), 64'b10);
    tick();
    @(negedge clk);
    tick();

    // Response stall on port 0 while port 1 waits.
    set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    rsp_rdy = 2'b10;
    push(0, 1'b0, 32'hDEAD_0010);
    @(negedge clk);
    chk("t3_gnt0", 64'(req_rdy), 64'b01);
    tick();
    set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
    push(1, 1'b0, 32'hDEAD_0020);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stall_vld", 64'(rsp_vld), 64'b01);
      chk("t3_stall_data", 64'(rsp_rd_data), 64'hDEAD_0010);
      chk("t3_stall_rdy", 64'(req_rdy), 64'b00);
      chk("t3_stall_en", 64'(mem_en), 64'd0);
      tick();
    end
    rsp_rdy = 2'b11;
    @(negedge clk);
    chk("t3_gnt1_on_acc", 64'(req_rdy), 64'b10);
    chk("t3_acc_vld", 64'(rsp_vld), 64'b01);
    tick();
    @(negedge clk);
    chk("t3_rsp1", 64'(rsp_vld), 64'b10);
    tick();
    @(negedge clk);
    tick();

    // Continuous requests from both ports: strict alternation.
    auto_drop = 1'b0;
    set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
    for (int k = 0; k < 8; k++) push(k % 2, 1'b0, (k % 2 == 0) ? 32'hDEAD_0010 : 32'hDEAD_0020);
    base = n_rsp;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t4_alt_gnt", 64'(req_rdy), (k % 2 == 0) ? 64'b01 : 64'b10);
      tick();
    end
    req_vld = '0;
    auto_drop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tick();
    end
    chk("t4_rsp_count", 64'(n_rsp - base), 64'd8);

    // Reset the cycle after a grant: in-flight response is dropped.
    set_req(0, 1'b0, 32'h30, 32'h0, 4'h0);
    @(negedge clk);
    chk("t5_gnt0", 64'(req_rdy), 64'b01);
    tick();
    rst_n = 1'b0;
    set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t5_rst_vld", 64'(rsp_vld), 64'b00);
      chk("t5_rst_rdy", 64'(req_rdy), 64'b00);
      chk("t5_rst_en", 64'(mem_en), 64'd0);
      tick();
    end
    rst_n = 1'b1;
    push(0, 1'b0, 32'hDEAD_0010);
    push(1, 1'b0, 32'hDEAD_0020);
    @(negedge clk);
    chk("t5_no_stale_rsp", 64'(rsp_vld), 64'b00);
    chk("t5_gnt0_after_rst", 64'(req_rdy), 64'b01);
    tick();
    @(negedge clk);
    chk("t5_gnt1", 64'(req_rdy), 64'b10);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tick();
    end
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    summary();
    $finish;
  end
endmodule
